// File: rtl/fp_align_ctrl_pkg.sv
// Shared definitions for the floating-point adder front end: widths,
// comparator result codes and the alignment FSM state type.
package fp_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

   localparam logic [1:0] EQUAL = 2'b00;
   localparam logic [1:0] SMALL = 2'b01;
   localparam logic [1:0] GREAT = 2'b10;
   localparam logic [1:0] ERROR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ALIGN = 2'b01,
      DONE  = 2'b10
   } align_state_t;

endpackage

// File: rtl/fp_align_ctrl_if.sv
// Operand/result bundle of the exponent-alignment controller.
interface fp_align_ctrl_if
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
);
   localparam int M = MAN_W + 1;

   logic             in_start;
   logic [EXP_W-1:0] in_exp_A;
   logic [EXP_W-1:0] in_exp_B;
   logic [M-1:0]     in_man_A;
   logic [M-1:0]     in_man_B;
   logic             out_busy;
   logic             out_done;
   logic [EXP_W-1:0] out_exp;
   logic [M-1:0]     out_man_A;
   logic [M-1:0]     out_man_B;
   logic             out_sticky;
   logic [1:0]       out_order;

   modport master (
      output in_start, in_exp_A, in_exp_B, in_man_A, in_man_B,
      input  out_busy, out_done, out_exp, out_man_A, out_man_B, out_sticky, out_order
   );

   modport slave (
      input  in_start, in_exp_A, in_exp_B, in_man_A, in_man_B,
      output out_busy, out_done, out_exp, out_man_A, out_man_B, out_sticky, out_order
   );

endinterface

// File: rtl/fp_align_ctrl_comparator.sv
// Unsigned magnitude comparator: 00 equal, 01 a<b, 10 a>b.
module comparator
   import fp_pkg::*;
#(
   parameter int SIZE = FP_EXP_W
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic [1:0]      code
);

   always_comb begin
      code = EQUAL;
      if (a > b)
         code = GREAT;
      else if (a < b)
         code = SMALL;
   end

endmodule

// File: rtl/fp_align_ctrl.sv
// Exponent-alignment controller: shifts the smaller operand's mantissa right
// one bit per cycle until both exponents match, collecting a sticky bit.
module fp_align_ctrl
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int MAN_W = FP_MAN_W
) (
   input  logic          in_clk,
   input  logic          in_rst_n,
   fp_align_ctrl_if.slave bus
);

   localparam int M = MAN_W + 1;

   align_state_t     state_reg;
   logic [EXP_W-1:0] exp_a_reg;
   logic [EXP_W-1:0] exp_b_reg;
   logic [M-1:0]     man_a_reg;
   logic [M-1:0]     man_b_reg;
   logic             sticky_reg;
   logic [1:0]       order_reg;
   logic             first_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [1:0]       cmp_code;
   logic [1:0]       code_eff;

   comparator #(.SIZE(EXP_W)) u_cmp (
      .a    (exp_a_reg),
      .b    (exp_b_reg),
      .code (cmp_code)
   );

   // The comparator never produces ERROR; folding it onto EQUAL guarantees termination.
   assign code_eff = (cmp_code == ERROR) ? EQUAL : cmp_code;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_reg  <= IDLE;
         exp_a_reg  <= '0;
         exp_b_reg  <= '0;
         man_a_reg  <= '0;
         man_b_reg  <= '0;
         sticky_reg <= 1'b0;
         order_reg  <= 2'b00;
         first_reg  <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.in_start) begin
                  exp_a_reg  <= bus.in_exp_A;
                  exp_b_reg  <= bus.in_exp_B;
                  man_a_reg  <= bus.in_man_A;
                  man_b_reg  <= bus.in_man_B;
                  sticky_reg <= 1'b0;
                  first_reg  <= 1'b1;
                  busy_reg   <= 1'b1;
                  state_reg  <= ALIGN;
               end
            end
            ALIGN: begin
               if (first_reg) begin
                  order_reg <= code_eff;
                  first_reg <= 1'b0;
               end
               case (code_eff)
                  SMALL: begin
                     // Once the mantissa is empty, further shifts change nothing: jump the exponent.
                     if (man_a_reg == '0) begin
                        exp_a_reg <= exp_b_reg;
                     end else begin
                        man_a_reg  <= man_a_reg >> 1;
                        sticky_reg <= sticky_reg | man_a_reg[0];
                        exp_a_reg  <= exp_a_reg + 1'b1;
                     end
                  end
                  GREAT: begin
                     if (man_b_reg == '0) begin
                        exp_b_reg <= exp_a_reg;
                     end else begin
                        man_b_reg  <= man_b_reg >> 1;
                        sticky_reg <= sticky_reg | man_b_reg[0];
                        exp_b_reg  <= exp_b_reg + 1'b1;
                     end
                  end
                  default: begin
                     done_reg  <= 1'b1;
                     state_reg <= DONE;
                  end
               endcase
            end
            DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.out_busy   = busy_reg;
   assign bus.out_done   = done_reg;
   assign bus.out_exp    = exp_a_reg;
   assign bus.out_man_A  = man_a_reg;
   assign bus.out_man_B  = man_b_reg;
   assign bus.out_sticky = sticky_reg;
   assign bus.out_order  = order_reg;

endmodule
